// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine owning the HI/LO pair: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, then a sign-fix/commit cycle.
module muldiv_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         flush_i,
  input  logic         hi_wr_i,
  input  logic         lo_wr_i,
  input  logic [W-1:0] wdata_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         dz_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic [1:0]   state_o
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            is_div_q, is_div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;

  logic            signed_op;
  logic [W-1:0]    abs_a, abs_b;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;

  assign signed_op = ~op_i[0];
  assign abs_a     = (signed_op && a_i[W-1]) ? -a_i : a_i;
  assign abs_b     = (signed_op && b_i[W-1]) ? -b_i : b_i;

  // acc_q low half holds the multiplier (or dividend/quotient) and shifts out as bits retire
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + ({1'b0, opb_q} & {(W+1){acc_q[0]}});
  assign div_shift = {rem_q, acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quot_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix   = rem_neg_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (hi_wr_i || lo_wr_i) begin
          if (hi_wr_i) hi_d = wdata_i;
          if (lo_wr_i) lo_d = wdata_i;
        end else if (start_i) begin
          if (op_i[1] && (b_i == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d   = S_CALC;
            is_div_d  = op_i[1];
            cnt_d     = '0;
            acc_d     = {{W{1'b0}}, abs_a};
            rem_d     = '0;
            opb_d     = abs_b;
            neg_d     = signed_op & (a_i[W-1] ^ b_i[W-1]);
            rem_neg_d = signed_op & op_i[1] & a_i[W-1];
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            // Restore when the trial subtraction goes negative
            rem_d = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_diff[W]};
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          if (cnt_q == CW'(W-1)) state_d = S_SIGN;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      S_SIGN: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          hi_d   = is_div_q ? rem_fix  : prod_fix[2*W-1:W];
          lo_d   = is_div_q ? quot_fix : prod_fix[W-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign dz_o    = dz_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of the MIPS32 core. It replaces the combinational 64-bit ALU product/quotient path feeding HI/LO with a 32-iteration shift-add / restoring-divide engine. It raises `busy` so the main control unit stalls PC and every HI/LO access until the result is committed. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- `W`, 32, operand width; the iteration count equals `W`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  W  rs operand, sampled at the accepting edge.
- `b`  in  W  rt operand, sampled at the accepting edge.
- `flush`  in  1  exception flush; cancels any operation in flight.
- `hi_wr`  in  1  MTHI request.
- `lo_wr`  in  1  MTLO request.
- `wdata`  in  W  MTHI/MTLO data.
- `busy`  out  1  operation in flight; the control unit stalls while high.
- `done`  out  1  one-cycle pulse when a result or divide-by-zero completes.
- `dz`  out  1  divide-by-zero flag; pulses together with `done`.
- `hi`  out  W  HI register.
- `lo`  out  W  LO register.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE, priority order:
  - `flush`: no action.
  - `hi_wr` / `lo_wr`: write `wdata` to HI and/or LO. Any `start` in the same cycle is ignored.
  - `start` with DIV/DIVU and `b`==0: stay in IDLE. Next cycle `done`=1 and `dz`=1; HI/LO unchanged.
  - `start` otherwise: latch `op`, latch |a| and |b| (absolute values for signed ops, raw for unsigned), latch result sign bits, clear `cnt`, go to CALC.
- CALC:
  - Multiply: radix-2 shift-add into a 2W accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle; W+1-bit partial remainder.
  - `cnt` counts 0..W-1; after iteration W-1, go to SIGN.
- SIGN:
  - Apply sign corrections:
    - MULT: negate the 2W product if a[W-1]^b[W-1].
    - DIV: negate the quotient if a^b sign bits differ; the remainder takes the sign of `a`.
  - Write HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient.
  - Go to IDLE with `done`=1 for one cycle.
- Arithmetic is modulo 2^W with no overflow trap. DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `flush` in CALC or SIGN: go to IDLE next edge; no `done`; HI/LO unchanged. `flush` beats `start` and any SIGN commit in the same cycle.
- `start`, `hi_wr`, `lo_wr` while `busy`: ignored. The control unit never issues them because it is stalled.

## Timing
- Reset (`rst_n` low, asynchronous, at any time including mid-operation):
  - State IDLE.
  - `busy`, `done`, `dz` = 0.
  - `hi`, `lo`, `cnt`, all internal registers = 0.
  - The operation in flight is discarded.
- Accepting edge E (IDLE and `start`): `busy`=1 from E until edge E+W+1.
- Edges E+1..E+W perform the iterations; edge E+W+1 executes SIGN.
- After edge E+W+1: `busy`=0, `done`=1, and the new HI/LO are visible, for one cycle. Total latency is W+1 cycles (33 when W=32).
- `done` and `dz` are registered outputs and are low in every other cycle.
- A `start` in the same cycle as `done` is accepted, giving back-to-back operations. `hi`/`lo` outputs are always registered values.
- Divide-by-zero: `done`=`dz`=1 in the single cycle after E; `busy` never rises.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` 33 cycles after the accepting edge; hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then a back-to-back MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 with HI=0x11, LO=0x22 -> next cycle `done`=`dz`=1, `busy` stays 0; HI=0x11, LO=0x22 unchanged.
- MTHI 0xA5A5A5A5 together with `start` in IDLE -> hi=0xA5A5A5A5 and no operation launched. MTLO while `busy` -> LO unchanged.
- Flush on the 10th CALC cycle -> `busy`=0 next cycle, no `done`, HI/LO unchanged. Separately, drive `rst_n` low mid-CALC (asynchronously, between edges) -> `busy`, `hi`, `lo` = 0 immediately, state IDLE.
